// File: rtl/version_pkg.sv
// Build identification constants stamped into the image at build time.
// Timestamp fields are BCD so the host can print them as-is.
package version_pkg;

   localparam logic [7:0]  VERSION_MAJOR = 8'd0;
   localparam logic [7:0]  VERSION_MINOR = 8'd0;
   localparam logic [7:0]  VERSION_PATCH = 8'd0;
   localparam logic [7:0]  VERSION_BUILD = 8'd64;

   localparam logic [15:0] BUILD_YEAR    = 16'h2025;
   localparam logic [7:0]  BUILD_MONTH   = 8'h11;
   localparam logic [7:0]  BUILD_DAY     = 8'h08;
   localparam logic [7:0]  BUILD_HOUR    = 8'h15;
   localparam logic [7:0]  BUILD_MINUTE  = 8'h03;
   localparam logic [7:0]  BUILD_SECOND  = 8'h23;

endpackage

// File: rtl/version_tx_pkg.sv
// Shared types and frame layout for the version record transmitter.
// Version fields are re-exported here so users only need this package.
package version_tx_pkg;

   import version_pkg::*;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } tx_state_t;

   localparam logic [7:0] C_VERSION_REC_LEN = 8'd12;
   localparam logic [7:0] C_DEFAULT_SYNC    = 8'hA5;

   // Byte position of each field within a frame
   localparam logic [3:0] IDX_SYNC   = 4'd0;
   localparam logic [3:0] IDX_LEN    = 4'd1;
   localparam logic [3:0] IDX_SEQ    = 4'd2;
   localparam logic [3:0] IDX_MAJOR  = 4'd3;
   localparam logic [3:0] IDX_MINOR  = 4'd4;
   localparam logic [3:0] IDX_PATCH  = 4'd5;
   localparam logic [3:0] IDX_BUILD  = 4'd6;
   localparam logic [3:0] IDX_YEAR_H = 4'd7;
   localparam logic [3:0] IDX_YEAR_L = 4'd8;
   localparam logic [3:0] IDX_MONTH  = 4'd9;
   localparam logic [3:0] IDX_DAY    = 4'd10;
   localparam logic [3:0] IDX_HOUR   = 4'd11;
   localparam logic [3:0] IDX_MINUTE = 4'd12;
   localparam logic [3:0] IDX_SECOND = 4'd13;
   localparam logic [3:0] IDX_CHK    = 4'd14;

   localparam logic [7:0] C_VER_MAJOR  = VERSION_MAJOR;
   localparam logic [7:0] C_VER_MINOR  = VERSION_MINOR;
   localparam logic [7:0] C_VER_PATCH  = VERSION_PATCH;
   localparam logic [7:0] C_VER_BUILD  = VERSION_BUILD;
   localparam logic [7:0] C_YEAR_HI    = BUILD_YEAR[15:8];
   localparam logic [7:0] C_YEAR_LO    = BUILD_YEAR[7:0];
   localparam logic [7:0] C_TS_MONTH   = BUILD_MONTH;
   localparam logic [7:0] C_TS_DAY     = BUILD_DAY;
   localparam logic [7:0] C_TS_HOUR    = BUILD_HOUR;
   localparam logic [7:0] C_TS_MINUTE  = BUILD_MINUTE;
   localparam logic [7:0] C_TS_SECOND  = BUILD_SECOND;

endpackage

// File: rtl/version_record_rom.sv
// Combinational byte selector for one position of the version record frame.
// SEQ and CHK come in from the transmitter; everything else is constant.
module version_record_rom
   import version_tx_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = C_DEFAULT_SYNC
) (
   input  logic [3:0] index,
   input  logic [7:0] seq,
   input  logic [7:0] chk,
   output logic [7:0] data
);

   always_comb begin
      data = 8'h00;
      case (index)
         IDX_SYNC:   data = SYNC_BYTE;
         IDX_LEN:    data = C_VERSION_REC_LEN;
         IDX_SEQ:    data = seq;
         IDX_MAJOR:  data = C_VER_MAJOR;
         IDX_MINOR:  data = C_VER_MINOR;
         IDX_PATCH:  data = C_VER_PATCH;
         IDX_BUILD:  data = C_VER_BUILD;
         IDX_YEAR_H: data = C_YEAR_HI;
         IDX_YEAR_L: data = C_YEAR_LO;
         IDX_MONTH:  data = C_TS_MONTH;
         IDX_DAY:    data = C_TS_DAY;
         IDX_HOUR:   data = C_TS_HOUR;
         IDX_MINUTE: data = C_TS_MINUTE;
         IDX_SECOND: data = C_TS_SECOND;
         IDX_CHK:    data = chk;
         default:    data = 8'h00;
      endcase
   end

endmodule

// File: rtl/version_record_tx.sv
// Streams the build identification as a framed, checksummed byte record
// over a valid/ready byte stream, with a rolling per-frame sequence number.
module version_record_tx
   import version_tx_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE        = C_DEFAULT_SYNC,
   parameter int         INCLUDE_CHECKSUM = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_i,
   output logic       busy_o,
   output logic [7:0] m_data_o,
   output logic       m_valid_o,
   input  logic       m_ready_i,
   output logic       m_last_o,
   output logic       done_o
);

   localparam logic [3:0] LAST_IDX = (INCLUDE_CHECKSUM != 0) ? IDX_CHK : IDX_SECOND;

   tx_state_t  state;
   tx_state_t  state_next;
   logic [3:0] idx;
   logic [7:0] seq;
   logic [7:0] acc;
   logic [7:0] chk;
   logic [7:0] rom_byte;
   logic       pending;
   logic       done_q;
   logic       hs;
   logic       last_hs;
   logic       start;

   assign hs      = m_valid_o && m_ready_i;
   assign last_hs = hs && (idx == LAST_IDX);
   assign start   = (state == ST_IDLE) && req_i;
   assign chk     = 8'h00 - acc;

   version_record_rom #(
      .SYNC_BYTE (SYNC_BYTE)
   ) u_rom (
      .index (idx),
      .seq   (seq),
      .chk   (chk),
      .data  (rom_byte)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A frame ends on its last handshake unless another request is queued
   // or arriving right now, in which case SEND continues with no gap.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (req_i) state_next = ST_SEND;
         ST_SEND: if (last_hs && !(pending || req_i)) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o    = (state == ST_SEND);
      m_valid_o = (state == ST_SEND);
      m_last_o  = (state == ST_SEND) && (idx == LAST_IDX);
      m_data_o  = (state == ST_SEND) ? rom_byte : 8'h00;
      done_o    = done_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= 4'd0;
      end else if (last_hs) begin
         idx <= 4'd0;
      end else if (hs) begin
         idx <= idx + 4'd1;
      end
   end

   // Checksum is built from bytes as they are accepted, so stalls never
   // disturb it; SYNC is deliberately left out of the sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= 8'h00;
      end else if (start || last_hs) begin
         acc <= 8'h00;
      end else if (hs && (idx != IDX_SYNC)) begin
         acc <= acc + rom_byte;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq <= 8'h00;
      end else if (last_hs) begin
         seq <= seq + 8'h01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
      end else if (last_hs) begin
         pending <= 1'b0;
      end else if ((state == ST_SEND) && req_i) begin
         pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= last_hs;
      end
   end

endmodule

// File: tb/tb_version_record_tx.sv
// Randomised self-checking bench for version_record_tx, with one instance
// carrying the checksum byte and one built without it.
module tb_version_record_tx;

   logic       clk;
   logic       rst_n;
   logic       req;
   logic       busy;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_last;
   logic       done;

   logic       req_nc;
   logic       busy_nc;
   logic [7:0] m_data_nc;
   logic       m_valid_nc;
   logic       ready_nc;
   logic       m_last_nc;
   logic       done_nc;

   int         checks;
   int         errors;
   logic [7:0] exp_seq;
   logic [7:0] exp_seq_nc;
   logic [7:0] last_chk;

   version_record_tx #(
      .SYNC_BYTE        (8'hA5),
      .INCLUDE_CHECKSUM (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req),
      .busy_o    (busy),
      .m_data_o  (m_data),
      .m_valid_o (m_valid),
      .m_ready_i (m_ready),
      .m_last_o  (m_last),
      .done_o    (done)
   );

   version_record_tx #(
      .SYNC_BYTE        (8'hA5),
      .INCLUDE_CHECKSUM (0)
   ) dut_nc (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_nc),
      .busy_o    (busy_nc),
      .m_data_o  (m_data_nc),
      .m_valid_o (m_valid_nc),
      .m_ready_i (ready_nc),
      .m_last_o  (m_last_nc),
      .done_o    (done_nc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected frame built from the documented field values and checksum rule
   function automatic logic [7:0] ref_byte(input int i, input logic [7:0] s);
      logic [7:0] f [0:14];
      logic [7:0] sum;
      f[0]  = 8'hA5; f[1]  = 8'd12; f[2]  = s;     f[3]  = 8'h00;
      f[4]  = 8'h00; f[5]  = 8'h00; f[6]  = 8'h40; f[7]  = 8'h20;
      f[8]  = 8'h25; f[9]  = 8'h11; f[10] = 8'h08; f[11] = 8'h15;
      f[12] = 8'h03; f[13] = 8'h23;
      sum = 8'h00;
      for (int k = 1; k <= 13; k++) sum = sum + f[k];
      f[14] = 8'h00 - sum;
      return f[i];
   endfunction

   task automatic apply_reset();
      rst_n    = 1'b0;
      req      = 1'b0;
      req_nc   = 1'b0;
      m_ready  = 1'b0;
      ready_nc = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_seq    = 8'h00;
      exp_seq_nc = 8'h00;
   endtask

   // Receives one checksummed frame starting at the current negedge
   task automatic recv_frame(input logic [7:0] seq_v, input int stall_pct,
                             input bit require_valid, input string tag);
      int         got;
      int         cycles;
      int         chk_stall;
      bit         prev_stall;
      bit         ready_now;
      logic [7:0] prev_data;
      logic       prev_last;
      got        = 0;
      cycles     = 0;
      chk_stall  = 0;
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      prev_last  = 1'b0;
      while (got < 15 && cycles < 400) begin
         cycles++;
         if (prev_stall) begin
            checks++;
            if (m_data !== prev_data || m_last !== prev_last) begin
               errors++;
               $display("[TB] FAIL %s stall_stable got %h/%b want %h/%b", tag, m_data, m_last, prev_data, prev_last);
            end
         end
         if (!m_valid) begin
            if (got > 0 || require_valid) begin
               checks++;
               errors++;
               $display("[TB] FAIL %s valid_gap at byte %0d got valid 0 want 1", tag, got);
               break;
            end
            m_ready    = 1'b1;
            prev_stall = 1'b0;
         end else begin
            ready_now = (stall_pct == 0) || (int'($urandom_range(99)) >= stall_pct);
            if (got == 14 && stall_pct > 0 && chk_stall < 3) begin
               ready_now = 1'b0;
               chk_stall++;
            end
            m_ready = ready_now;
            if (ready_now) begin
               checks++;
               if (m_data !== ref_byte(got, seq_v)) begin
                  errors++;
                  $display("[TB] FAIL %s data[%0d] got %h want %h", tag, got, m_data, ref_byte(got, seq_v));
               end
               checks++;
               if (m_last !== (got == 14)) begin
                  errors++;
                  $display("[TB] FAIL %s last[%0d] got %b want %b", tag, got, m_last, (got == 14));
               end
               checks++;
               if (busy !== 1'b1) begin
                  errors++;
                  $display("[TB] FAIL %s busy[%0d] got %b want 1", tag, got, busy);
               end
               if (got > 0) begin
                  checks++;
                  if (done !== 1'b0) begin
                     errors++;
                     $display("[TB] FAIL %s done_mid[%0d] got %b want 0", tag, got, done);
                  end
               end
               if (got == 14) last_chk = m_data;
               got++;
            end
            prev_stall = !ready_now;
            prev_data  = m_data;
            prev_last  = m_last;
         end
         @(negedge clk);
      end
      checks++;
      if (got < 15) begin
         errors++;
         $display("[TB] FAIL %s timeout got %0d bytes want 15", tag, got);
      end else if (done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s done_pulse got %b want 1", tag, done);
      end
   endtask

   task automatic check_idle(input string tag);
      checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || done !== 1'b0 || m_data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL %s idle got busy %b valid %b last %b done %b data %h want 0 0 0 0 00",
                  tag, busy, m_valid, m_last, done, m_data);
      end
   endtask

   task automatic pulse_req();
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (busy !== 1'b1 || m_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL req_latency got busy %b valid %b want 1 1", busy, m_valid);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      rst_n = 1'b0;
      #1;
      check_idle("reset");
      checks++;
      if (busy_nc !== 1'b0 || m_valid_nc !== 1'b0 || m_last_nc !== 1'b0 || done_nc !== 1'b0 || m_data_nc !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_nc got busy %b valid %b last %b done %b data %h want all 0",
                  busy_nc, m_valid_nc, m_last_nc, done_nc, m_data_nc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("reset_release");
   endtask

   task automatic test_single();
      m_ready = 1'b1;
      pulse_req();
      recv_frame(exp_seq, 0, 1'b1, "single");
      checks++;
      if (last_chk !== 8'h1B) begin
         errors++;
         $display("[TB] FAIL single_chk got %h want 1b", last_chk);
      end
      exp_seq = exp_seq + 8'h01;
      @(negedge clk);
      check_idle("single_after");
   endtask

   task automatic test_backpressure();
      for (int r = 0; r < 3; r++) begin
         pulse_req();
         recv_frame(exp_seq, 45, 1'b1, "backpressure");
         exp_seq = exp_seq + 8'h01;
         @(negedge clk);
         check_idle("backpressure_after");
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] chk_lit [0:2];
      chk_lit[0] = 8'h1B;
      chk_lit[1] = 8'h1A;
      chk_lit[2] = 8'h19;
      apply_reset();
      m_ready = 1'b1;
      req     = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         if (k == 2) req = 1'b0;
         recv_frame(exp_seq, 0, 1'b1, "back_to_back");
         checks++;
         if (last_chk !== chk_lit[k]) begin
            errors++;
            $display("[TB] FAIL b2b_chk[%0d] got %h want %h", k, last_chk, chk_lit[k]);
         end
         exp_seq = exp_seq + 8'h01;
      end
      @(negedge clk);
      check_idle("back_to_back_after");
   endtask

   task automatic test_no_checksum();
      int got;
      int cycles;
      for (int r = 0; r < 2; r++) begin
         ready_nc = 1'b1;
         req_nc   = 1'b1;
         @(negedge clk);
         req_nc = 1'b0;
         got    = 0;
         cycles = 0;
         while (got < 14 && cycles < 100) begin
            cycles++;
            if (m_valid_nc) begin
               checks++;
               if (m_data_nc !== ref_byte(got, exp_seq_nc) || m_last_nc !== (got == 13)) begin
                  errors++;
                  $display("[TB] FAIL nochk byte[%0d] got %h/%b want %h/%b", got, m_data_nc, m_last_nc,
                           ref_byte(got, exp_seq_nc), (got == 13));
               end
               if (got == 13) begin
                  checks++;
                  if (m_data_nc !== 8'h23) begin
                     errors++;
                     $display("[TB] FAIL nochk_last_byte got %h want 23", m_data_nc);
                  end
               end
               got++;
            end
            @(negedge clk);
         end
         checks++;
         if (got < 14 || done_nc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nochk_done got bytes %0d done %b want 14 1", got, done_nc);
         end
         exp_seq_nc = exp_seq_nc + 8'h01;
         @(negedge clk);
         checks++;
         if (busy_nc !== 1'b0 || m_valid_nc !== 1'b0 || done_nc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nochk_after got busy %b valid %b done %b want 0 0 0", busy_nc, m_valid_nc, done_nc);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      m_ready = 1'b1;
      pulse_req();
      for (int k = 0; k < 7; k++) @(negedge clk);
      checks++;
      if (m_data !== 8'h20 || m_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_position got %h/%b want 20/1", m_data, m_valid);
      end
      rst_n = 1'b0;
      #1;
      check_idle("midreset_async");
      @(negedge clk);
      rst_n   = 1'b1;
      exp_seq = 8'h00;
      @(negedge clk);
      @(negedge clk);
      check_idle("midreset_abandoned");
      pulse_req();
      recv_frame(exp_seq, 20, 1'b1, "after_reset");
      exp_seq = exp_seq + 8'h01;
      @(negedge clk);
      check_idle("after_reset_idle");
   endtask

   task automatic test_seq_wrap();
      apply_reset();
      m_ready = 1'b1;
      req     = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 257; k++) begin
         if (k == 256) req = 1'b0;
         recv_frame(exp_seq, 0, 1'b1, "seq_wrap");
         if (k == 255) begin
            checks++;
            if (last_chk !== 8'h1C) begin
               errors++;
               $display("[TB] FAIL seq_ff_chk got %h want 1c", last_chk);
            end
         end
         exp_seq = exp_seq + 8'h01;
      end
      @(negedge clk);
      check_idle("seq_wrap_after");
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      exp_seq    = 8'h00;
      exp_seq_nc = 8'h00;
      last_chk   = 8'h00;
      rst_n      = 1'b0;
      req        = 1'b0;
      req_nc     = 1'b0;
      m_ready    = 1'b0;
      ready_nc   = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_no_checksum();
      test_reset_mid_frame();
      test_seq_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/version_record_tx.md
# version_record_tx

Streams the build identification (major/minor/patch/build version and build timestamp from `version_pkg`) as a framed, checksummed byte record over a valid/ready byte stream. It sits between the control/status logic that requests an identification readout and the host-facing byte transport, such as the UART or debug-link TX path. Each frame carries a rolling sequence number so the host can detect dropped records.

## Interface
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.
- `INCLUDE_CHECKSUM`, default 1: 1 appends a checksum byte; 0 omits it and ends the frame on SECOND.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `req_i`  in  1  level-sampled frame request.
- `busy_o`  out  1  high while a frame is in progress.
- `m_data_o`  out  8  stream byte.
- `m_valid_o`  out  1  stream byte valid.
- `m_ready_i`  in  1  downstream accepts byte.
- `m_last_o`  out  1  marks the final byte of a frame (qualified by `m_valid_o`).
- `done_o`  out  1  one-cycle pulse after the final byte handshake.

## Operation
- Frame byte order, index 0..13:
  - 0: SYNC.
  - 1: LEN = 8'd12.
  - 2: SEQ.
  - 3-6: MAJOR, MINOR, PATCH, BUILD.
  - 7-8: YEAR[15:8], YEAR[7:0].
  - 9-13: MONTH, DAY, HOUR, MINUTE, SECOND.
  - 14: CHK, present only if `INCLUDE_CHECKSUM`.
- CHK is the two's complement of the 8-bit modulo-256 sum of bytes 1..13, so bytes 1..14 sum to 0 mod 256. SYNC is excluded from the sum.
- CHK is computed with a running 8-bit accumulator that adds each byte on its handshake. The accumulator clears when a frame starts. A combinational precompute is not used.
- SEQ is an 8-bit counter:
  - resets to 0;
  - increments by 1 after each completed frame (on the last handshake);
  - wraps 255 -> 0.
- States:
  - IDLE: `m_valid_o` = 0. If `req_i` = 1, go to SEND with index 0.
  - SEND: `m_valid_o` = 1. On `m_valid_o && m_ready_i`, the index increments. On the handshake of the last byte, go to IDLE, or stay in SEND with index 0 if a request is pending.
- Pending request: `req_i` sampled high while in SEND sets a one-deep pending flag. Further requests in the same frame are absorbed. The flag is consumed at the last handshake.
- Stream rules:
  - `m_data_o` and `m_last_o` stay stable while `m_valid_o && !m_ready_i`.
  - `m_valid_o` never drops mid-frame.
- `busy_o` = (state == SEND).
- Version bytes are taken directly from the `version_pkg` constants. There is no runtime input for them.

## Timing
- Reset values:
  - `m_valid_o` = 0, `m_last_o` = 0, `done_o` = 0, `busy_o` = 0, `m_data_o` = 8'h00;
  - SEQ = 0, pending = 0, accumulator = 0, state = IDLE.
- Latency: `req_i` high at edge N in IDLE gives `m_valid_o` = 1 with SYNC after edge N. `busy_o` rises at the same point.
- Throughput: one byte per cycle with `m_ready_i` held high, so a frame takes 15 cycles (14 with `INCLUDE_CHECKSUM` = 0).
- Back-to-back frames: with pending set, the next SYNC is presented in the cycle after the last handshake. There is no valid gap and `busy_o` stays high.
- `done_o` pulses once, in the cycle after every last handshake, including back-to-back frames.
- Ready deassert: indefinite stalls on any byte, including CHK, must not change data or the checksum.
- Simultaneous `req_i` with the last handshake sets pending, so the next frame follows.
- Reset mid-frame:
  - all outputs go to reset values immediately (asynchronously);
  - the partial frame is abandoned and never resumed;
  - SEQ returns to 0.

## Structure
- Shared package `version_tx_pkg` holds:
  - the state enum;
  - `C_VERSION_REC_LEN` = 12;
  - byte-index localparams for each field;
  - the default sync constant.
- The version constants remain in `version_pkg`; `version_tx_pkg` imports it.
- One natural sub-module: `version_record_rom`, a combinational map from index to byte that selects SYNC/LEN/SEQ/version/timestamp/CHK. The FSM, counters, pending flag and accumulator stay in `version_record_tx`.

## Test plan
All expected CHK values assume package values 0.0.0 build 64, 2025-11-08 15:03:23.
- Single request, ready held high:
  - bytes A5 0C 00 00 00 00 40 20 25 11 08 15 03 23 1B;
  - `m_last_o` on 1B; `done_o` one cycle later; `busy_o` falls.
- Random ready backpressure, including a stall on CHK: identical byte sequence, and data is stable during every stall.
- `req_i` held high for three frames:
  - contiguous frames with SEQ 00, 01, 02 and CHK 1B, 1A, 19;
  - no valid gap; three `done_o` pulses.
- Preload 255 completed frames, then request: SEQ = FF, CHK = 1C. The next frame has SEQ = 00.
- `INCLUDE_CHECKSUM` = 0: 14 bytes, with `m_last_o` on the SECOND byte (23).
- Assert `rst_n` low at byte index 7, then request: outputs are 0 immediately, and the new frame starts with SYNC and SEQ = 00.
